// File: rtl/spi_cmd_rx.sv
// spi_cmd_rx: oversampled SPI-slave word receiver feeding a valid/ready FIFO with threshold interrupt
// Optional build macro SPI_CMD_RX_FRAME_TAG_EN: tags each stored word and adds rd_first (first word after CS falls).
// Ports: clk, rst (sync, active-high); spi_sck/spi_mosi/spi_cs async SPI pins (CS active-low);
// rd_data/rd_valid/rd_ready FIFO read port; int_thresh/int_out level interrupt (0 disables);
// ovf/ovf_clr sticky overflow; level FIFO occupancy.
module spi_cmd_rx #(
  parameter int WORD_W    = 8,
  parameter int DEPTH     = 4,
  parameter int CPHA_MODE = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       spi_sck,
  input  logic                       spi_mosi,
  input  logic                       spi_cs,
  output logic [WORD_W-1:0]          rd_data,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  input  logic [$clog2(DEPTH):0]     int_thresh,
  output logic                       int_out,
  output logic                       ovf,
  input  logic                       ovf_clr,
`ifdef SPI_CMD_RX_FRAME_TAG_EN
  output logic                       rd_first,
`endif
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(WORD_W);
`ifdef SPI_CMD_RX_FRAME_TAG_EN
  localparam int EW = WORD_W + 1;
`else
  localparam int EW = WORD_W;
`endif
  localparam logic [BW-1:0] LAST = BW'(WORD_W - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t            state_q, state_d;
  logic [2:0]        sck_q, sck_d;
  logic [1:0]        mosi_q, mosi_d, cs_q, cs_d, settle_q, settle_d;
  logic              armed_q, armed_d;
  logic [BW-1:0]     bitcnt_q, bitcnt_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic              push_q, push_d;
  logic [EW-1:0]     word_q, word_d;
  logic [EW-1:0]     mem_q [DEPTH];
  logic [EW-1:0]     mem_d [DEPTH];
  logic [LW-1:0]     wr_q, wr_d, rd_q, rd_d, level_q, level_d;
  logic              ovf_q, ovf_d, int_q, int_d;
`ifdef SPI_CMD_RX_FRAME_TAG_EN
  logic              first_q, first_d;
`endif
  logic              samp, full, pop, wr_en;
  // sck_q[2] is the extra stage used only for edge detection
  assign samp = (CPHA_MODE != 0) ? (~sck_q[1] & sck_q[2]) : (sck_q[1] & ~sck_q[2]);
  assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign rd_valid = level_q != '0;
  assign pop = rd_valid & rd_ready;
  // a full FIFO still accepts a push when a pop frees the head in the same cycle
  assign wr_en = push_q & (~full | pop);
  assign rd_data = mem_q[rd_q[AW-1:0]][WORD_W-1:0];
`ifdef SPI_CMD_RX_FRAME_TAG_EN
  assign rd_first = mem_q[rd_q[AW-1:0]][WORD_W];
`endif
  assign int_out = int_q;
  assign ovf = ovf_q;
  assign level = level_q;
  always_comb begin
    sck_d = {sck_q[1:0], spi_sck};
    mosi_d = {mosi_q[0], spi_mosi};
    cs_d = {cs_q[0], spi_cs};
    settle_d = {settle_q[0], 1'b1};
    // after reset, CS must be seen high through settled synchronisers before a frame starts
    armed_d = armed_q | (settle_q[1] & cs_q[1]);
    state_d = state_q;
    bitcnt_d = bitcnt_q;
    shift_d = shift_q;
    push_d = 1'b0;
    word_d = word_q;
`ifdef SPI_CMD_RX_FRAME_TAG_EN
    first_d = first_q;
`endif
    if (state_q == IDLE) begin
      bitcnt_d = '0;
      shift_d = '0;
`ifdef SPI_CMD_RX_FRAME_TAG_EN
      first_d = 1'b1;
`endif
      state_d = (!cs_q[1] && armed_q) ? SHIFT : IDLE;
    end else if (cs_q[1]) begin
      state_d = IDLE;
      bitcnt_d = '0;
      shift_d = '0;
    end else if (samp) begin
      shift_d = {shift_q[WORD_W-2:0], mosi_q[1]};
      bitcnt_d = (bitcnt_q == LAST) ? '0 : bitcnt_q + 1'b1;
      if (bitcnt_q == LAST) begin
        push_d = 1'b1;
`ifdef SPI_CMD_RX_FRAME_TAG_EN
        word_d = {first_q, shift_d};
        first_d = 1'b0;
`else
        word_d = shift_d;
`endif
      end
    end
    mem_d = mem_q;
    if (wr_en) mem_d[wr_q[AW-1:0]] = word_q;
    wr_d = wr_q + LW'(wr_en);
    rd_d = rd_q + LW'(pop);
    level_d = level_q + LW'(wr_en) - LW'(pop);
    ovf_d = (push_q & full & ~pop) | (ovf_q & ~ovf_clr);
    int_d = (int_thresh != '0) && (level_q >= int_thresh);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q <= '0;
      mosi_q <= '0;
      cs_q <= '1;
      settle_q <= '0;
      armed_q <= 1'b0;
      state_q <= IDLE;
      bitcnt_q <= '0;
      shift_q <= '0;
      push_q <= 1'b0;
      word_q <= '0;
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
      ovf_q <= 1'b0;
      int_q <= 1'b0;
`ifdef SPI_CMD_RX_FRAME_TAG_EN
      first_q <= 1'b0;
`endif
    end else begin
      sck_q <= sck_d;
      mosi_q <= mosi_d;
      cs_q <= cs_d;
      settle_q <= settle_d;
      armed_q <= armed_d;
      state_q <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q <= shift_d;
      push_q <= push_d;
      word_q <= word_d;
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      level_q <= level_d;
      ovf_q <= ovf_d;
      int_q <= int_d;
`ifdef SPI_CMD_RX_FRAME_TAG_EN
      first_q <= first_d;
`endif
    end
  end
endmodule
